// File: rtl/fft_pkg.sv
// Shared FFT constants, controller state type and the quarter-wave cosine
// table generator used by the twiddle ROM.
package fft_pkg;

    localparam int N_POINT = 16;
    localparam int LOG2N   = 4;
    localparam int TW_W    = 8;

    localparam int HALF    = N_POINT / 2;
    localparam int QUARTER = N_POINT / 4;
    localparam int Q_MAX   = 2 ** (TW_W - 1) - 1;
    localparam int QIW     = $clog2(QUARTER + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Q[i] = round(Q_MAX * cos(2*pi*i/N_POINT)) for i = 0..N_POINT/4.
    // Evaluated at elaboration with a 2^30 fixed-point Taylor series, so no
    // real-number support is needed from synthesis.
    function automatic logic signed [TW_W-1:0] q_val(input int i);
        longint pi_fx;
        longint x;
        longint x2;
        longint term;
        longint acc;
        longint q;
        pi_fx = 64'sd3373259426;                     // pi * 2^30
        x     = (pi_fx * longint'(2 * i)) / longint'(N_POINT);
        x2    = (x * x) >>> 30;
        term  = longint'(1) <<< 30;
        acc   = term;
        for (int n = 1; n <= 12; n++) begin
            term = -(((term * x2) >>> 30) / longint'((2 * n - 1) * (2 * n)));
            acc  = acc + term;
        end
        q = (longint'(Q_MAX) * acc + (longint'(1) <<< 29)) >>> 30;
        if (q < 0) q = 0;
        if (q > longint'(Q_MAX)) q = longint'(Q_MAX);
        return TW_W'(q);
    endfunction

endpackage

// File: rtl/twiddle_gen_if.sv
// Coefficient stream from the twiddle generator to the multiplier.
interface twiddle_gen_if;
    import fft_pkg::*;

    logic                    tw_valid;
    logic                    tw_ready;
    logic signed [TW_W-1:0]  tw_re;
    logic signed [TW_W-1:0]  tw_im;
    logic [LOG2N-1:0]        tw_stage;
    logic                    tw_last;

    modport master (output tw_valid, tw_re, tw_im, tw_stage, tw_last, input tw_ready);
    modport slave  (input tw_valid, tw_re, tw_im, tw_stage, tw_last, output tw_ready);
endinterface

// File: rtl/twiddle_rom.sv
// Combinational twiddle lookup: index k -> W^k using a quarter-wave cosine
// table and its symmetries (sin taken as a shifted cosine).
module twiddle_rom
    import fft_pkg::*;
(
    input  logic [LOG2N-2:0]        k_i,
    output logic signed [TW_W-1:0]  re_o,
    output logic signed [TW_W-1:0]  im_o
);

    logic signed [TW_W-1:0] q_tab [QUARTER+1];
    logic [LOG2N-1:0]       kx;

    for (genvar i = 0; i <= QUARTER; i++) begin : g_q
        assign q_tab[i] = q_val(i);
    end

    assign kx = {1'b0, k_i};

    // First quarter reads the table directly; second quarter mirrors it.
    // Negation is safe since every entry is at most Q_MAX.
    always_comb begin
        if (kx <= LOG2N'(QUARTER)) begin
            re_o = q_tab[QIW'(kx)];
            im_o = -q_tab[QIW'(LOG2N'(QUARTER) - kx)];
        end else begin
            re_o = -q_tab[QIW'(LOG2N'(HALF) - kx)];
            im_o = -q_tab[QIW'(kx - LOG2N'(QUARTER))];
        end
    end

endmodule

// File: rtl/twiddle_gen.sv
// Sequential twiddle-factor source for the radix-2 DIT FFT. Walks stage s and
// butterfly b, presents W^k with k = (b mod 2^s) << (LOG2N-1-s) on a
// valid/ready stream, and reports frame completion with a done pulse.
// Optional feature: define TWIDDLE_IFFT_EN to add the "inverse" input, which
// selects conjugate twiddles for the whole frame (sampled on start).
module twiddle_gen
    import fft_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            clear,
`ifdef TWIDDLE_IFFT_EN
    input  logic            inverse,
`endif
    output logic            busy,
    output logic            done,
    twiddle_gen_if.master   tw
);

    localparam logic [LOG2N-1:0] S_LAST = LOG2N'(LOG2N - 1);
    localparam logic [LOG2N-2:0] B_LAST = (LOG2N - 1)'(HALF - 1);

    state_e                  state_q, state_d;
    logic [LOG2N-1:0]        s_q, s_d;
    logic [LOG2N-2:0]        b_q, b_d;
    logic                    valid_q, valid_d;
    logic                    last_q, last_d;
    logic signed [TW_W-1:0]  re_q, re_d;
    logic signed [TW_W-1:0]  im_q, im_d;
    logic                    load;
    logic [LOG2N-2:0]        mask_d;
    logic [LOG2N-2:0]        k_d;
    logic signed [TW_W-1:0]  rom_re, rom_im;
`ifdef TWIDDLE_IFFT_EN
    logic                    inv_q, inv_d;
`endif

    // State, counters and registered stream outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            s_q     <= '0;
            b_q     <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            re_q    <= '0;
            im_q    <= '0;
`ifdef TWIDDLE_IFFT_EN
            inv_q   <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q <= state_d;
            s_q     <= s_d;
            b_q     <= b_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            re_q    <= re_d;
            im_q    <= im_d;
`ifdef TWIDDLE_IFFT_EN
            inv_q   <= inv_d;
`endif
        end
    end

    // Next state and counters; load flags that a new coefficient is presented.
    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned (no latches).
        state_d = state_q;
        s_d     = s_q;
        b_d     = b_q;
        load    = 1'b0;
`ifdef TWIDDLE_IFFT_EN
        inv_d   = inv_q;
`endif
        if (clear) begin
            state_d = IDLE;
            s_d     = '0;
            b_d     = '0;
        end else begin
            unique case (state_q)
                IDLE: if (start) begin
                    state_d = RUN;
                    s_d     = '0;
                    b_d     = '0;
                    load    = 1'b1;
`ifdef TWIDDLE_IFFT_EN
                    inv_d   = inverse;
`endif
                end
                RUN: if (valid_q && tw.tw_ready) begin
                    if (last_q) begin
                        state_d = DONE;
                    end else begin
                        load = 1'b1;
                        if (b_q == B_LAST) begin
                            b_d = '0;
                            s_d = s_q + 1'b1;
                        end else begin
                            b_d = b_q + 1'b1;
                        end
                    end
                end
                DONE: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Twiddle index for the coefficient about to be presented.
    assign mask_d = ~({(LOG2N - 1){1'b1}} << s_d);
    assign k_d    = (b_d & mask_d) << (S_LAST - s_d);

    twiddle_rom u_rom (
        .k_i  (k_d),
        .re_o (rom_re),
        .im_o (rom_im)
    );

    // Output register update: load a new coefficient, hold while stalled,
    // drop valid at frame end or on abort.
    always_comb begin
        valid_d = valid_q;
        last_d  = last_q;
        re_d    = re_q;
        im_d    = im_q;
        if (clear || state_d != RUN) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            last_d  = (s_d == S_LAST) && (b_d == B_LAST);
            re_d    = rom_re;
`ifdef TWIDDLE_IFFT_EN
            im_d    = inv_d ? -rom_im : rom_im;
`else
            im_d    = rom_im;
`endif
        end
    end

    assign tw.tw_valid = valid_q;
    assign tw.tw_re    = re_q;
    assign tw.tw_im    = im_q;
    assign tw.tw_stage = s_q;
    assign tw.tw_last  = last_q;
    assign busy        = (state_q == RUN);
    assign done        = (state_q == DONE);

endmodule

// File: tb/tb_twiddle_gen.sv
// Directed bench for twiddle_gen (N_POINT=16, TW_W=8). Expected twiddles come
// from a hand-computed table of W^k, k = 0..7.
module tb_twiddle_gen;

    logic clk;
    logic rst_n;
    logic start;
    logic clear;
    logic busy;
    logic done;
`ifdef TWIDDLE_IFFT_EN
    logic inverse;
`endif

    twiddle_gen_if tw_if ();

    twiddle_gen dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .clear (clear),
`ifdef TWIDDLE_IFFT_EN
        .inverse (inverse),
`endif
        .busy  (busy),
        .done  (done),
        .tw    (tw_if)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // W^k = cos(2*pi*k/16) - j*sin(2*pi*k/16), scaled by 127 and rounded.
    int exp_re [8] = '{127, 117,  90,   49,    0,  -49,  -90, -117};
    int exp_im [8] = '{  0, -49, -90, -117, -127, -117,  -90,  -49};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Check the coefficient presented as transfer number t (0-based).
    task automatic check_coeff(input int t, input bit inv);
        int s;
        int b;
        int k;
        int im;
        s  = t / 8;
        b  = t % 8;
        k  = (b % (1 << s)) << (3 - s);
        im = inv ? -exp_im[k] : exp_im[k];
        check($sformatf("valid t=%0d", t), 32'(tw_if.tw_valid), 1);
        check($sformatf("re t=%0d", t), tw_if.tw_re, exp_re[k]);
        check($sformatf("im t=%0d", t), tw_if.tw_im, im);
        check($sformatf("stage t=%0d", t), 32'(tw_if.tw_stage), s);
        check($sformatf("last t=%0d", t), 32'(tw_if.tw_last), (t == 31) ? 1 : 0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        clear = 1'b0;
        tw_if.tw_ready = 1'b1;
`ifdef TWIDDLE_IFFT_EN
        inverse = 1'b0;
`endif

        // Reset state
        repeat (2) tick();
        check("rst valid", 32'(tw_if.tw_valid), 0);
        check("rst re", tw_if.tw_re, 0);
        check("rst im", tw_if.tw_im, 0);
        check("rst stage", 32'(tw_if.tw_stage), 0);
        check("rst last", 32'(tw_if.tw_last), 0);
        check("rst busy", 32'(busy), 0);
        check("rst done", 32'(done), 0);
        rst_n = 1'b1;
        tick();
        check("idle valid", 32'(tw_if.tw_valid), 0);

        // Frame A: full frame, a 3-cycle stall at #13, a start while busy at #6
        start = 1'b1;
        tick();
        start = 1'b0;
        check("A busy", 32'(busy), 1);
        for (int t = 0; t < 32; t++) begin
            check_coeff(t, 1'b0);
            if (t == 12) begin
                tw_if.tw_ready = 1'b0;
                repeat (3) begin
                    tick();
                    check_coeff(12, 1'b0);
                end
                tw_if.tw_ready = 1'b1;
            end
            if (t == 5) start = 1'b1;
            tick();
            start = 1'b0;
            if (t < 31) check($sformatf("A done early t=%0d", t), 32'(done), 0);
        end
        check("A done pulse", 32'(done), 1);
        check("A valid after last", 32'(tw_if.tw_valid), 0);
        tick();
        check("A done one cycle", 32'(done), 0);
        check("A busy after", 32'(busy), 0);
        check("A valid idle", 32'(tw_if.tw_valid), 0);
        repeat (3) tick();
        check("A no second done", 32'(done), 0);

        // Frame B: clear at transfer 10
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 0; t < 10; t++) begin
            check_coeff(t, 1'b0);
            if (t < 9) tick();
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("B clear valid", 32'(tw_if.tw_valid), 0);
        check("B clear busy", 32'(busy), 0);
        check("B clear done", 32'(done), 0);
        tick();
        check("B no done", 32'(done), 0);

        // clear beats a simultaneous start
        clear = 1'b1;
        start = 1'b1;
        tick();
        clear = 1'b0;
        start = 1'b0;
        check("clr+start valid", 32'(tw_if.tw_valid), 0);
        check("clr+start busy", 32'(busy), 0);

        // Frame C: restart from s=0,b=0, then reset at transfer 20
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 0; t < 20; t++) begin
            check_coeff(t, 1'b0);
            if (t < 19) tick();
        end
        rst_n = 1'b0;
        #1;
        check("C rst valid", 32'(tw_if.tw_valid), 0);
        check("C rst busy", 32'(busy), 0);
        check("C rst stage", 32'(tw_if.tw_stage), 0);
        check("C rst re", tw_if.tw_re, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("C no done", 32'(done), 0);
        check("C idle valid", 32'(tw_if.tw_valid), 0);

        // Frame D: restart after reset begins at s=0,b=0
        start = 1'b1;
        tick();
        start = 1'b0;
        check_coeff(0, 1'b0);
        tick();
        check_coeff(1, 1'b0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("D clear valid", 32'(tw_if.tw_valid), 0);

`ifdef TWIDDLE_IFFT_EN
        // Frame E: conjugate twiddles
        inverse = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        inverse = 1'b0;
        for (int t = 0; t < 30; t++) begin
            check_coeff(t, 1'b1);
            if (t < 29) tick();
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("E clear valid", 32'(tw_if.tw_valid), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
